// File: rtl/scope_capture.sv
// Capture buffer behind the scope trigger: circular sample memory with pre-trigger
// history, post-trigger fill, then a frozen buffer read out one sample per byte.
module scope_capture #(
  parameter int NSIG       = 1,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NSIG-1:0]       sigin,
  input  logic                  triggered,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [DEPTH_LOG2-1:0] pretrig,
  input  logic                  rd_next,
  output logic [7:0]            rd_data,
  output logic [1:0]            state,
  output logic [DEPTH_LOG2-1:0] trig_addr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FILL_MAX = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARM = 2'd1, S_RUN = 2'd2, S_DONE = 2'd3} state_e;
  typedef logic [DEPTH_LOG2-1:0] addr_t;

  logic [NSIG-1:0] mem [DEPTH];

  state_e              state_q, state_d;
  addr_t               wr_ptr_q, wr_ptr_d;
  addr_t               rd_ptr_q, rd_ptr_d;
  addr_t               trig_addr_q, trig_addr_d;
  addr_t               pretrig_q, pretrig_d;
  addr_t               post_q, post_d;
  logic [DEPTH_LOG2:0] fill_q, fill_d;
  logic [7:0]          rd_data_q, rd_data_d;
  logic                wr_en;
  logic                accept;

  // A trigger only counts once enough history has been stored.
  assign accept = (state_q == S_ARM) && triggered && (fill_q >= {1'b0, pretrig_q});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (arm) state_d = S_ARM;
      S_ARM: begin
        if (arm)         state_d = S_ARM;
        else if (accept) state_d = (pretrig_q == '1) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (arm)                      state_d = S_ARM;
        else if (post_q == addr_t'(1)) state_d = S_DONE;
      end
      S_DONE: if (arm) state_d = S_ARM;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  always_comb begin
    wr_en       = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    trig_addr_d = trig_addr_q;
    pretrig_d   = pretrig_q;
    post_d      = post_q;
    fill_d      = fill_q;
    if (!abort) begin
      if (arm) begin
        wr_ptr_d  = '0;
        fill_d    = '0;
        pretrig_d = pretrig;
      end else begin
        case (state_q)
          S_ARM, S_RUN: begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
            if (state_q == S_RUN) post_d = post_q - 1'b1;
            if (accept) begin
              trig_addr_d = wr_ptr_q;
              post_d      = ~pretrig_q;
            end
            // Oldest sample sits right after the final write.
            if (state_d == S_DONE) rd_ptr_d = wr_ptr_q + 1'b1;
          end
          S_DONE: if (rd_next) rd_ptr_d = rd_ptr_q + 1'b1;
          default: ;
        endcase
      end
    end
    rd_data_d = '0;
    if (state_q == S_DONE) rd_data_d[NSIG-1:0] = mem[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= sigin;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      trig_addr_q <= '0;
      pretrig_q   <= '0;
      post_q      <= '0;
      fill_q      <= '0;
      rd_data_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      trig_addr_q <= trig_addr_d;
      pretrig_q   <= pretrig_d;
      post_q      <= post_d;
      fill_q      <= fill_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign state     = state_q;
  assign rd_data   = rd_data_q;
  assign trig_addr = trig_addr_q;

endmodule

// File: tb/tb_scope_capture.sv
// Directed + randomized bench for scope_capture: an 8-bit and a 3-bit instance
// share stimulus and are checked against a sample-history model.
module tb_scope_capture;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sigin;
  logic       triggered, arm, abort, rd_next;
  logic [3:0] pretrig;
  logic [7:0] rd_data8, rd_data3;
  logic [1:0] state8, state3;
  logic [3:0] ta8, ta3;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  scope_capture #(.NSIG(8), .DEPTH_LOG2(4)) u8 (
    .clk(clk), .rst_n(rst_n), .sigin(sigin), .triggered(triggered), .arm(arm),
    .abort(abort), .pretrig(pretrig), .rd_next(rd_next), .rd_data(rd_data8),
    .state(state8), .trig_addr(ta8));

  scope_capture #(.NSIG(3), .DEPTH_LOG2(4)) u3 (
    .clk(clk), .rst_n(rst_n), .sigin(sigin[2:0]), .triggered(triggered), .arm(arm),
    .abort(abort), .pretrig(pretrig), .rd_next(rd_next), .rd_data(rd_data3),
    .state(state3), .trig_addr(ta3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [1:0] exp);
    chk({tag, "_st8"}, 32'(state8), 32'(exp));
    chk({tag, "_st3"}, 32'(state3), 32'(exp));
  endtask

  task automatic do_arm(input int pt);
    pretrig = 4'(pt);
    arm = 1'b1;
    step();
    arm = 1'b0;
    chk_state("arm", 2'd1);
  endtask

  // Arm, then feed samples with a single trigger at sample index tf (tf >= pt).
  task automatic arm_and_trigger(input int pt, input int tf);
    do_arm(pt);
    for (int f = 0; f <= tf; f++) begin
      sigin = 8'($urandom);
      triggered = (f == tf);
      step();
    end
    triggered = 1'b0;
  endtask

  // Full capture against a model: sample history indexed by write number,
  // first trigger at index >= pt wins, buffer = history[tf-pt .. tf+DEPTH-1-pt].
  task automatic capture(input int pt, input int t1, input int t2, input bit cnt, input bit rnd);
    logic [7:0] smp[$];
    logic [7:0] sv, exp;
    bit acc, trg;
    int f, tf, post, idx;
    do_arm(pt);
    f = 0; acc = 1'b0; tf = 0;
    while (!acc) begin
      if (f > 400) begin
        n_cmp++; n_err++;
        $error("FAIL arm_timeout: observed no trigger accept expected accept");
        triggered = 1'b0;
        return;
      end
      sv = cnt ? 8'(f) : 8'($urandom);
      trg = (f == t1) || (f == t2) || (rnd && ($urandom_range(7) == 0)) || (f == pt + 40);
      sigin = sv; triggered = trg;
      smp.push_back(sv);
      if (trg && f >= pt) begin acc = 1'b1; tf = f; end
      step();
      f++;
      if (!acc) chk_state("arm_hold", 2'd1);
    end
    post = 15 - pt;
    chk_state("trig", (post == 0) ? 2'd3 : 2'd2);
    chk("trig_addr8", 32'(ta8), 32'(tf % 16));
    chk("trig_addr3", 32'(ta3), 32'(tf % 16));
    for (int r = post; r > 0; r--) begin
      sv = cnt ? 8'(f) : 8'($urandom);
      sigin = sv; triggered = 1'($urandom_range(1));
      smp.push_back(sv);
      step();
      f++;
      chk_state("run", (r == 1) ? 2'd3 : 2'd2);
    end
    triggered = 1'b0;
    step();
    idx = tf - pt;
    chk("rd_b0_8", 32'(rd_data8), 32'(smp[idx]));
    chk("rd_b0_3", 32'(rd_data3), 32'({5'd0, smp[idx][2:0]}));
    rd_next = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      exp = smp[idx + k - 1];
      chk($sformatf("rd8_b%0d", k - 1), 32'(rd_data8), 32'(exp));
      chk($sformatf("rd3_b%0d", k - 1), 32'(rd_data3), 32'({5'd0, exp[2:0]}));
    end
    rd_next = 1'b0;
    step();
    chk("rd_wrap8", 32'(rd_data8), 32'(smp[idx]));
    chk("rd_wrap3", 32'(rd_data3), 32'({5'd0, smp[idx][2:0]}));
    chk_state("done_hold", 2'd3);
  endtask

  initial begin
    rst_n = 1'b0; sigin = '0; triggered = 1'b0; arm = 1'b0; abort = 1'b0;
    rd_next = 1'b0; pretrig = '0;
    step(); step();
    chk_state("reset", 2'd0);
    chk("reset_rd", 32'(rd_data8), 32'd0);
    chk("reset_ta", 32'(ta8), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sigin = 8'($urandom); triggered = 1'($urandom_range(1)); rd_next = 1'($urandom_range(1));
      step();
      chk_state("idle", 2'd0);
    end
    triggered = 1'b0; rd_next = 1'b0;

    capture(4, 10, -1, 1'b1, 1'b0);   // trig_addr 10, bytes 0x06..0x15
    capture(4, 2, 7, 1'b1, 1'b0);     // early trigger ignored, arm from DONE
    capture(15, 20, -1, 1'b0, 1'b0);  // post == 0
    capture(0, 3, -1, 1'b0, 1'b0);    // byte 0 is the trigger sample
    for (int n = 0; n < 6; n++) capture(int'($urandom_range(15)), -1, -1, 1'b0, 1'b1);

    // abort during RUN, rd_next ignored afterwards
    arm_and_trigger(4, 6);
    chk_state("pre_abort", 2'd2);
    abort = 1'b1; rd_next = 1'b1;
    step();
    abort = 1'b0;
    chk_state("abort_run", 2'd0);
    step();
    rd_next = 1'b0;
    chk_state("abort_idle", 2'd0);
    chk("abort_rd", 32'(rd_data8), 32'd0);

    // arm and abort together
    pretrig = 4'd3; arm = 1'b1; abort = 1'b1;
    step();
    arm = 1'b0; abort = 1'b0;
    chk_state("arm_abort", 2'd0);

    // abort in DONE clears rd_data one cycle later
    capture(5, 9, -1, 1'b0, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_state("abort_done", 2'd0);
    step();
    chk("abort_done_rd8", 32'(rd_data8), 32'd0);
    chk("abort_done_rd3", 32'(rd_data3), 32'd0);

    // async reset mid-RUN
    arm_and_trigger(2, 5);
    chk_state("pre_rst", 2'd2);
    #2 rst_n = 1'b0;
    #1;
    chk_state("rst_async", 2'd0);
    chk("rst_rd", 32'(rd_data8), 32'd0);
    chk("rst_ta8", 32'(ta8), 32'd0);
    chk("rst_ta3", 32'(ta3), 32'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sigin = 8'($urandom); triggered = 1'b1;
      step();
      chk_state("post_rst", 2'd0);
    end
    triggered = 1'b0;
    capture(7, 12, -1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
